header_framer: RTL and testbench
================================

# header_framer

Parametrised Avalon-ST header framer: the successor to the fixed 256-bit header adder in the AES stream path. It either prepends a configurable multi-word header to each packet (insert mode) or removes a fixed-length header from each packet (strip mode). Mode is selected per packet. Optional per-stream statistics counters are exposed for the register controller.

## Interface
- DATA_W, 32, stream word width in bits
- HDR_WORDS, 8, header length in words (≥1); default gives a 256-bit header
- CNT_W, 16, width of statistics counters
- clk  in  1  sole clock
- rst  in  1  reset, asynchronous, active-high
- mode  in  1  0 = insert, 1 = strip; sampled at packet start only
- header_data  in  HDR_WORDS*DATA_W  header to insert; word 0 = MSB slice; sampled at packet start
- in_valid / in_ready  in / out  1  input handshake
- in_data  in  DATA_W  input word
- in_sop / in_eop  in  1  input packet delimiters
- out_valid / out_ready  out / in  1  output handshake
- out_data  out  DATA_W  output word
- out_sop / out_eop  out  1  output packet delimiters
- cnt_clear  in  1  synchronous clear of all counters
- word_in_cnt, word_out_cnt, pkt_cnt, err_cnt  out  CNT_W  statistics counters
- strip_err  out  1  one-cycle pulse: packet dropped because it was too short to strip

## Operation
- Clock `clk`; reset `rst` is asynchronous and active-high.
- The output stage is a single register (`out_*`). It loads when `!out_valid || out_ready`. Every output-producing state stalls while the stage cannot load.
- FSM states:
  - IDLE
    - `in_ready = in_valid & ~in_sop`: stray non-sop beats are accepted and dropped.
    - On `in_valid & in_sop`, latch `mode` and `header_data` and clear the word index. Next state is HDR if mode=0, else STRIP. The sop beat is not consumed in IDLE.
  - HDR
    - `in_ready = 0`.
    - Emit header word idx = `header_data[(HDR_WORDS-idx)*DATA_W-1 -: DATA_W]`, with `out_sop = 1` for idx=0 and `out_eop = 0`.
    - After word HDR_WORDS-1 is loaded, go to BODY.
  - STRIP
    - `in_ready = 1`; accepted beats are discarded and idx increments.
    - After the HDR_WORDS-th beat is accepted, go to BODY with a first-beat flag set.
    - If `in_eop` is accepted on any beat while in STRIP: pulse `strip_err`, increment `err_cnt`, emit nothing, go to IDLE.
  - BODY
    - `in_ready` equals the output-stage load condition; accepted beats are copied to the output.
    - `out_sop` is 1 only on the first beat after STRIP (strip mode). In insert mode it is always 0.
    - `in_sop` is ignored.
    - The beat with `in_eop` is forwarded with `out_eop = 1`, then the FSM returns to IDLE.
- Counters wrap modulo 2^CNT_W. `cnt_clear` has priority over any same-cycle increment.
  - `word_in_cnt` increments on each `in_valid & in_ready`, including dropped beats.
  - `word_out_cnt` increments on each `out_valid & out_ready`.
  - `pkt_cnt` increments on each output beat transferred with `out_eop`.
- Header changes mid-packet have no effect; the latched copy is used.

## Timing
- Reset values: all outputs 0; state IDLE; idx 0.
- Reset asserted mid-packet aborts the packet immediately. Downstream sees a truncated packet, and the bench treats that as legal.
- Insert mode:
  - sop visible in IDLE at cycle T → header word 0 is on `out_*` at T+2 (T+1 is the HDR load cycle).
  - With `out_ready` held high, header words occupy HDR_WORDS consecutive cycles, then the body streams at 1 word/cycle.
  - Per-packet overhead is 1 IDLE cycle plus HDR_WORDS header cycles.
- Strip mode: discards 1 word/cycle; the first body word appears 1 cycle after its acceptance.
- Pass-through latency in BODY is 1 cycle. `out_valid` and `out_data` hold stable while `out_valid & ~out_ready`.
- `strip_err` is asserted the cycle after the offending eop is accepted.

## Configuration
- `HEADER_FRAMER_STATS_EN`
  - Defined: the four counters and `cnt_clear` are implemented as described.
  - Undefined: the counters are tied to 0, `cnt_clear` is ignored, and no counter logic is synthesised. `strip_err` is unaffected.

## Test plan
- Insert, HDR_WORDS=8, DATA_W=32, header f0e1d2c3…aaaa, 4-word packet 1,2,3,4 with out_ready=1 → 12 output words: f0e1d2c3 first (sop), …, aaaaaaaa, 1,2,3,4 (eop on 4); `pkt_cnt=1`, `word_out_cnt=12`.
- Strip, 10-word packet 0..9 → output 8 (sop), 9 (eop); `word_in_cnt=10`, `word_out_cnt=2`.
- Strip, 5-word packet with eop on word 4 → no output, `strip_err` pulses once, `err_cnt=1`; the next packet then strips correctly.
- Insert with out_ready toggling 1,0,1,0… → output sequence identical to the first scenario, no duplicates or drops; data stable while stalled.
- Reset asserted during BODY of a 20-word insert → next cycle all outputs 0; a following packet framed correctly from idx 0.
- Counters at 16'hFFFF with one more beat → wrap to 0; `cnt_clear` on the same cycle as an increment → 0.

Source files
------------

// File: rtl/header_framer.sv
// Avalon-ST header framer: prepends or strips a HDR_WORDS-word header per packet.
// Optional statistics counters are enabled by defining HEADER_FRAMER_STATS_EN.
module header_framer #(
  parameter int DATA_W    = 32,
  parameter int HDR_WORDS = 8,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mode,
  input  logic [HDR_WORDS*DATA_W-1:0] header_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_sop,
  input  logic                        in_eop,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_sop,
  output logic                        out_eop,
  input  logic                        cnt_clear,
  output logic [CNT_W-1:0]            word_in_cnt,
  output logic [CNT_W-1:0]            word_out_cnt,
  output logic [CNT_W-1:0]            pkt_cnt,
  output logic [CNT_W-1:0]            err_cnt,
  output logic                        strip_err
);

  localparam int IW = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(HDR_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    STRIP,
    BODY
  } state_t;

  state_t                        state, state_n;
  logic [IW-1:0]                 idx, idx_n;
  logic [HDR_WORDS*DATA_W-1:0]   hdr_q, hdr_n;
  logic                          first_q, first_n;
  logic                          ov_n, os_n, oe_n, err_n;
  logic [DATA_W-1:0]             od_n;
  logic                          load;
  logic [DATA_W-1:0]             hdr_word [HDR_WORDS];

  // word 0 is the most significant slice of the latched header
  for (genvar i = 0; i < HDR_WORDS; i++) begin : g_hdr
    assign hdr_word[i] = hdr_q[(HDR_WORDS-i)*DATA_W-1 -: DATA_W];
  end

  assign load = !out_valid || out_ready;

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    hdr_n    = hdr_q;
    first_n  = first_q;
    ov_n     = out_valid;
    od_n     = out_data;
    os_n     = out_sop;
    oe_n     = out_eop;
    err_n    = 1'b0;
    in_ready = 1'b0;
    if (load) begin
      ov_n = 1'b0;
      os_n = 1'b0;
      oe_n = 1'b0;
    end
    unique case (state)
      IDLE: begin
        in_ready = in_valid & ~in_sop;
        if (in_valid && in_sop) begin
          hdr_n   = header_data;
          idx_n   = '0;
          state_n = mode ? STRIP : HDR;
        end
      end
      HDR: begin
        if (load) begin
          ov_n = 1'b1;
          od_n = hdr_word[idx];
          os_n = (idx == '0);
          if (idx == LAST) begin
            idx_n   = '0;
            first_n = 1'b0;
            state_n = BODY;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      STRIP: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_eop) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else if (idx == LAST) begin
            idx_n   = '0;
            first_n = 1'b1;
            state_n = BODY;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      BODY: begin
        in_ready = load;
        if (in_valid && load) begin
          ov_n    = 1'b1;
          od_n    = in_data;
          os_n    = first_q;
          oe_n    = in_eop;
          first_n = 1'b0;
          if (in_eop) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      hdr_q     <= '0;
      first_q   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      strip_err <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      hdr_q     <= hdr_n;
      first_q   <= first_n;
      out_valid <= ov_n;
      out_data  <= od_n;
      out_sop   <= os_n;
      out_eop   <= oe_n;
      strip_err <= err_n;
    end
  end

`ifdef HEADER_FRAMER_STATS_EN
  logic in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_in_cnt  <= '0;
      word_out_cnt <= '0;
      pkt_cnt      <= '0;
      err_cnt      <= '0;
    end else if (cnt_clear) begin
      word_in_cnt  <= '0;
      word_out_cnt <= '0;
      pkt_cnt      <= '0;
      err_cnt      <= '0;
    end else begin
      if (in_fire)             word_in_cnt  <= word_in_cnt + 1'b1;
      if (out_fire)            word_out_cnt <= word_out_cnt + 1'b1;
      if (out_fire && out_eop) pkt_cnt      <= pkt_cnt + 1'b1;
      if (err_n)               err_cnt      <= err_cnt + 1'b1;
    end
  end
`else
  logic unused_cnt_clear;

  assign unused_cnt_clear = cnt_clear;
  assign word_in_cnt      = '0;
  assign word_out_cnt     = '0;
  assign pkt_cnt          = '0;
  assign err_cnt          = '0;
`endif

endmodule

// File: tb/tb_header_framer.sv
// Directed table-driven bench for header_framer (insert, strip, stall, reset, counters).
module tb_header_framer;
  localparam int DW = 32;
  localparam int HW = 8;
  localparam int CW = 16;
`ifdef HEADER_FRAMER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic mode;
  logic [HW*DW-1:0] header_data;
  logic in_valid, in_ready, in_sop, in_eop;
  logic [DW-1:0] in_data;
  logic out_valid, out_ready, out_sop, out_eop;
  logic [DW-1:0] out_data;
  logic cnt_clear;
  logic [CW-1:0] word_in_cnt, word_out_cnt, pkt_cnt, err_cnt;
  logic strip_err;

  header_framer #(.DATA_W(DW), .HDR_WORDS(HW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .header_data(header_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop),
    .cnt_clear(cnt_clear),
    .word_in_cnt(word_in_cnt), .word_out_cnt(word_out_cnt),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .strip_err(strip_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        s;
    logic        e;
  } beat_t;

  typedef struct {
    logic        mode;
    int          len;
    logic [31:0] start;
    logic        stall;
    int          exp_n;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    int          exp_err;
  } vec_t;

  beat_t got[$];
  beat_t expq[$];
  int n_vec = 0;
  int n_bad = 0;
  int err_seen = 0;
  logic tog = 1'b0;
  logic held_v = 1'b0;
  logic [31:0] held_d;

  assign header_data = {32'hf0e1d2c3, 32'hb4a59687, 32'h78695a4b, 32'h3c2d1e0f,
                        32'h01234567, 32'h89abcdef, 32'hdeadbeef, 32'haaaaaaaa};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hword(input int i);
    logic [HW*DW-1:0] h;
    h = header_data;
    return h[(HW-i)*DW-1 -: DW];
  endfunction

  // sink side: drives out_ready, checks stall stability, collects beats
  always begin
    @(negedge clk);
    out_ready = tog ? ~out_ready : 1'b1;
    #4;
    if (held_v) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", out_data, held_d);
    end
    held_v = out_valid && !out_ready;
    held_d = out_data;
    if (out_valid && out_ready) got.push_back('{out_data, out_sop, out_eop});
    if (strip_err) err_seen++;
  end

  // called just after a negedge; returns just after a negedge
  task automatic send_pkt(input logic m, input int len, input logic [31:0] start,
                          input int abort_after);
    logic acc;
    for (int i = 0; i < len; i++) begin
      if (i == abort_after) break;
      mode     = m;
      in_valid = 1'b1;
      in_data  = start + i;
      in_sop   = (i == 0);
      in_eop   = (i == len - 1);
      acc = 1'b0;
      for (int t = 0; t < 100 && !acc; t++) begin
        #4;
        acc = in_ready;
        @(negedge clk);
      end
      if (!acc) begin
        n_vec++;
        n_bad++;
        $display("FAIL accept_timeout: beat %0d never accepted", i);
        break;
      end
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    vec_t v;
    int nw;

    vt[0] = '{1'b0, 4,  32'h1,   1'b0, 12, 32'hf0e1d2c3, 32'h4,    0};
    vt[1] = '{1'b1, 10, 32'h0,   1'b0, 2,  32'h8,        32'h9,    0};
    vt[2] = '{1'b1, 5,  32'h100, 1'b0, 0,  32'h0,        32'h0,    1};
    vt[3] = '{1'b1, 10, 32'h10,  1'b0, 2,  32'h18,       32'h19,   0};
    vt[4] = '{1'b0, 4,  32'h1,   1'b1, 12, 32'hf0e1d2c3, 32'h4,    0};
    vt[5] = '{1'b1, 9,  32'h20,  1'b0, 1,  32'h28,       32'h28,   0};
    vt[6] = '{1'b1, 8,  32'h30,  1'b0, 0,  32'h0,        32'h0,    1};
    vt[7] = '{1'b0, 1,  32'h55,  1'b0, 9,  32'hf0e1d2c3, 32'h55,   0};

    rst = 1'b1;
    mode = 1'b0;
    in_valid = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    cnt_clear = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_sop", 32'(out_sop), 32'd0);
    chk("rst_out_eop", 32'(out_eop), 32'd0);
    chk("rst_strip_err", 32'(strip_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_word_in_cnt", 32'(word_in_cnt), 32'd0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      v = vt[k];
      cnt_clear = 1'b1;
      @(negedge clk);
      cnt_clear = 1'b0;
      got.delete();
      err_seen = 0;
      tog = v.stall;
      send_pkt(v.mode, v.len, v.start, -1);
      repeat (40) @(negedge clk);
      tog = 1'b0;
      @(negedge clk);

      expq.delete();
      if (!v.mode) begin
        for (int i = 0; i < HW; i++) expq.push_back('{hword(i), i == 0, 1'b0});
        for (int i = 0; i < v.len; i++)
          expq.push_back('{v.start + i, 1'b0, i == v.len - 1});
      end else if (v.len > HW) begin
        for (int i = HW; i < v.len; i++)
          expq.push_back('{v.start + i, i == HW, i == v.len - 1});
      end

      chk($sformatf("v%0d_count", k), got.size(), v.exp_n);
      chk($sformatf("v%0d_strip_err", k), err_seen, v.exp_err);
      if (got.size() > 0) begin
        chk($sformatf("v%0d_first", k), got[0].d, v.exp_first);
        chk($sformatf("v%0d_last", k), got[got.size()-1].d, v.exp_last);
      end
      for (int i = 0; i < got.size() && i < expq.size(); i++) begin
        chk($sformatf("v%0d_w%0d_data", k, i), got[i].d, expq[i].d);
        chk($sformatf("v%0d_w%0d_sop", k, i), 32'(got[i].s), 32'(expq[i].s));
        chk($sformatf("v%0d_w%0d_eop", k, i), 32'(got[i].e), 32'(expq[i].e));
      end
      chk($sformatf("v%0d_word_in_cnt", k), 32'(word_in_cnt), STATS ? v.len : 0);
      chk($sformatf("v%0d_word_out_cnt", k), 32'(word_out_cnt), STATS ? v.exp_n : 0);
      chk($sformatf("v%0d_pkt_cnt", k), 32'(pkt_cnt), (STATS && v.exp_n > 0) ? 1 : 0);
      chk($sformatf("v%0d_err_cnt", k), 32'(err_cnt), STATS ? v.exp_err : 0);
    end

    // reset in the middle of a long insert body
    got.delete();
    send_pkt(1'b0, 20, 32'h200, 11);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", out_data, 32'd0);
    chk("mid_rst_out_sop", 32'(out_sop), 32'd0);
    chk("mid_rst_out_eop", 32'(out_eop), 32'd0);
    chk("mid_rst_word_out_cnt", 32'(word_out_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got.delete();
    send_pkt(1'b0, 2, 32'h300, -1);
    repeat (30) @(negedge clk);
    chk("post_rst_count", got.size(), 32'd10);
    if (got.size() == 10) begin
      chk("post_rst_w0", got[0].d, 32'hf0e1d2c3);
      chk("post_rst_w0_sop", 32'(got[0].s), 32'd1);
      chk("post_rst_w7", got[7].d, 32'haaaaaaaa);
      chk("post_rst_w9", got[9].d, 32'h301);
      chk("post_rst_w9_eop", 32'(got[9].e), 32'd1);
    end

    // counter wrap and clear priority using stray beats dropped in IDLE
    nw = STATS ? 65535 : 5;
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    in_valid = 1'b1;
    in_sop = 1'b0;
    repeat (nw) @(negedge clk);
    chk("cnt_full", 32'(word_in_cnt), STATS ? 32'hffff : 32'd0);
    chk("stray_no_output", 32'(word_out_cnt), 32'd0);
    @(negedge clk);
    chk("cnt_wrap", 32'(word_in_cnt), 32'd0);
    @(negedge clk);
    chk("cnt_after_wrap", 32'(word_in_cnt), STATS ? 32'd1 : 32'd0);
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    chk("cnt_clear_prio", 32'(word_in_cnt), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
